// File: rtl/delta_multi_down_counter.sv
// delta_multi_down_counter
// Multi-channel enable-driven down counter. Each channel counts accepted
// enable strobes down from its period, flags the first step (restart) and the
// final step (last) of every period, and keeps a saturating count of completed
// periods. Channels can run periodically or as one-shots that wait for arm.

`ifndef DELTA_SIM_LEN
`define DELTA_SIM_LEN 8
`endif

module delta_multi_down_counter #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = `DELTA_SIM_LEN,
    parameter int CNT_W  = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         enable,
    input  logic [NUM_CH*WIDTH-1:0]   period,
    input  logic [NUM_CH-1:0]         mode,
    input  logic [NUM_CH-1:0]         arm,
    input  logic [NUM_CH-1:0]         clear,
    output logic [NUM_CH-1:0]         restart,
    output logic [NUM_CH-1:0]         last,
    output logic [NUM_CH-1:0]         armed,
    output logic [NUM_CH-1:0]         done_pulse,
    output logic [NUM_CH*CNT_W-1:0]   periods_done
);

    // Remaining steps of the current period; 0 means the next accepted
    // enable starts a new period. The live period input is only consulted
    // when count is 0, so the value loaded here is the period in use.
    logic [WIDTH-1:0] count    [NUM_CH];
    logic [CNT_W-1:0] done_cnt [NUM_CH];
    logic [WIDTH-1:0] eff_period [NUM_CH];
    logic [NUM_CH-1:0] acc;
    logic [NUM_CH-1:0] completion;

    // Per-channel step acceptance and the combinational period flags
    always_comb begin
        acc        = enable & armed;
        restart    = '0;
        last       = '0;
        completion = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            eff_period[c] = (period[c*WIDTH +: WIDTH] == '0) ? WIDTH'(1)
                                                              : period[c*WIDTH +: WIDTH];
            restart[c]    = acc[c] && (count[c] == '0);
            last[c]       = armed[c] && ((count[c] == WIDTH'(1)) ||
                                         ((count[c] == '0) && (eff_period[c] == WIDTH'(1))));
            completion[c] = acc[c] && last[c];
        end
    end

    // Counter, arm state, completion pulse and saturating period counter
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                count[c]    <= '0;
                done_cnt[c] <= '0;
            end
            armed      <= '1;
            done_pulse <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (acc[c]) begin
                    if (count[c] == '0) begin
                        count[c] <= eff_period[c] - WIDTH'(1);
                    end else begin
                        count[c] <= count[c] - WIDTH'(1);
                    end
                end

                done_pulse[c] <= completion[c];

                if (clear[c]) begin
                    done_cnt[c] <= '0;
                end else if (completion[c] && (done_cnt[c] != {CNT_W{1'b1}})) begin
                    done_cnt[c] <= done_cnt[c] + CNT_W'(1);
                end

                if (completion[c] && mode[c]) begin
                    armed[c] <= 1'b0;
                end else if (arm[c]) begin
                    armed[c] <= 1'b1;
                end
            end
        end
    end

    // Flatten the per-channel period counters onto the output bus
    always_comb begin
        periods_done = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            periods_done[c*CNT_W +: CNT_W] = done_cnt[c];
        end
    end

endmodule

// File: tb/tb_delta_multi_down_counter.sv
// tb_delta_multi_down_counter
// Directed scenarios followed by random traffic, every cycle compared against
// a reference model that tracks each channel as "steps taken in the current
// period" rather than a remaining-count register.

`timescale 1ns/1ps

module tb_delta_multi_down_counter;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 4;
    localparam int CNT_W  = 2;
    localparam int PD_MAX = (1 << CNT_W) - 1;

    logic                     clock;
    logic                     reset;
    logic [NUM_CH-1:0]        enable;
    logic [NUM_CH*WIDTH-1:0]  period;
    logic [NUM_CH-1:0]        mode;
    logic [NUM_CH-1:0]        arm;
    logic [NUM_CH-1:0]        clear;
    logic [NUM_CH-1:0]        restart;
    logic [NUM_CH-1:0]        last;
    logic [NUM_CH-1:0]        armed;
    logic [NUM_CH-1:0]        done_pulse;
    logic [NUM_CH*CNT_W-1:0]  periods_done;

    int check_count;
    int error_count;

    // Reference model: position inside the period (0 = idle) and period in use
    int m_pos   [NUM_CH];
    int m_len   [NUM_CH];
    bit m_armed [NUM_CH];
    bit m_done  [NUM_CH];
    int m_pd    [NUM_CH];

    delta_multi_down_counter #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .period       (period),
        .mode         (mode),
        .arm          (arm),
        .clear        (clear),
        .restart      (restart),
        .last         (last),
        .armed        (armed),
        .done_pulse   (done_pulse),
        .periods_done (periods_done)
    );

    // Free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_pos[c]   = 0;
            m_len[c]   = 0;
            m_armed[c] = 1'b1;
            m_done[c]  = 1'b0;
            m_pd[c]    = 0;
        end
    endtask

    // Drive one cycle of inputs, compare all outputs, advance the model, clock
    task automatic applyStimulus(input logic rst, input logic [NUM_CH-1:0] en,
                                 input logic [NUM_CH*WIDTH-1:0] per,
                                 input logic [NUM_CH-1:0] md,
                                 input logic [NUM_CH-1:0] am,
                                 input logic [NUM_CH-1:0] clr);
        int  eff;
        bit  acc;
        bit  exp_last;
        bit  comp;
        @(negedge clock);
        reset  = rst;
        enable = en;
        period = per;
        mode   = md;
        arm    = am;
        clear  = clr;
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            eff      = (per[c*WIDTH +: WIDTH] == 0) ? 1 : int'(per[c*WIDTH +: WIDTH]);
            acc      = en[c] && m_armed[c];
            exp_last = m_armed[c] && ((m_pos[c] == 0) ? (eff == 1) : (m_pos[c] == m_len[c] - 1));
            comp     = acc && exp_last;
            checkOutput($sformatf("restart ch%0d", c), 32'(restart[c]), 32'(acc && (m_pos[c] == 0)));
            checkOutput($sformatf("last ch%0d", c), 32'(last[c]), 32'(exp_last));
            checkOutput($sformatf("armed ch%0d", c), 32'(armed[c]), 32'(m_armed[c]));
            checkOutput($sformatf("done_pulse ch%0d", c), 32'(done_pulse[c]), 32'(m_done[c]));
            checkOutput($sformatf("periods_done ch%0d", c),
                        32'(periods_done[c*CNT_W +: CNT_W]), 32'(m_pd[c]));
            if (!rst) begin
                if (acc) begin
                    if (m_pos[c] == 0) begin
                        m_len[c] = eff;
                    end
                    m_pos[c]++;
                    if (comp) m_pos[c] = 0;
                end
                m_done[c] = comp;
                if (clr[c])    m_pd[c] = 0;
                else if (comp) m_pd[c] = (m_pd[c] < PD_MAX) ? m_pd[c] + 1 : PD_MAX;
                if (comp && md[c]) m_armed[c] = 1'b0;
                else if (am[c])    m_armed[c] = 1'b1;
            end
        end
        if (rst) modelReset();
        @(posedge clock);
    endtask

    function automatic logic [NUM_CH*WIDTH-1:0] mkPeriod(input int p0, input int p1,
                                                         input int p2, input int p3);
        return {WIDTH'(p3), WIDTH'(p2), WIDTH'(p1), WIDTH'(p0)};
    endfunction

    // Directed scenarios followed by randomized traffic
    initial begin
        logic [NUM_CH*WIDTH-1:0] per;
        logic [NUM_CH-1:0] md;
        check_count = 0;
        error_count = 0;
        reset  = 1'b1;
        enable = '0;
        period = '0;
        mode   = '0;
        arm    = '0;
        clear  = '0;
        repeat (2) @(posedge clock);
        modelReset();
        #1;
        checkOutput("reset armed", 32'(armed), 32'hF);
        checkOutput("reset periods_done", 32'(periods_done), 32'h0);
        checkOutput("reset done_pulse", 32'(done_pulse), 32'h0);

        // Periodic ch0 period 3, six enables
        per = mkPeriod(3, 2, 4, 1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'b0001, per, 4'b0000, 4'b0, 4'b0);
        applyStimulus(1'b0, 4'b0000, per, 4'b0000, 4'b0, 4'b0);
        checkOutput("periodic pd ch0 == 2", 32'(periods_done[1:0]), 32'd2);

        // One-shot ch1 period 2: five enables, arm, two enables
        md = 4'b0010;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'b0010, per, md, 4'b0, 4'b0);
        checkOutput("oneshot disarmed ch1", 32'(armed[1]), 32'd0);
        applyStimulus(1'b0, 4'b0010, per, md, 4'b0010, 4'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 4'b0010, per, md, 4'b0, 4'b0);
        applyStimulus(1'b0, 4'b0000, per, md, 4'b0, 4'b0);
        checkOutput("oneshot pd ch1 == 2", 32'(periods_done[3:2]), 32'd2);

        // ch2 period 4, switched to 2 after the second enable
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 4'b0100, per, 4'b0, 4'b0, 4'b0);
        per = mkPeriod(3, 2, 2, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'b0100, per, 4'b0, 4'b0, 4'b0);
        applyStimulus(1'b0, 4'b0000, per, 4'b0, 4'b0, 4'b0);
        checkOutput("period change pd ch2 == 2", 32'(periods_done[5:4]), 32'd2);

        // ch3 period 0 then 1, saturation, then clear coincident with completion
        per = mkPeriod(3, 2, 2, 0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 4'b1000, per, 4'b0, 4'b0, 4'b0);
        per = mkPeriod(3, 2, 2, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b1000, per, 4'b0, 4'b0, 4'b0);
        checkOutput("saturated pd ch3 == 3", 32'(periods_done[7:6]), 32'd3);
        applyStimulus(1'b0, 4'b1000, per, 4'b0, 4'b0, 4'b1000);
        #1;
        checkOutput("clear wins pd ch3", 32'(periods_done[7:6]), 32'd0);
        checkOutput("clear done_pulse ch3", 32'(done_pulse[3]), 32'd1);

        // Reset mid-period with ch0 two steps remaining, then all channels
        per = mkPeriod(4, 2, 3, 1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 4'b0001, per, 4'b0, 4'b0, 4'b0);
        applyStimulus(1'b1, 4'b0001, per, 4'b0, 4'b0, 4'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'b1111, per, 4'b0, 4'b0, 4'b0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [NUM_CH-1:0] en, am, clr;
            for (int c = 0; c < NUM_CH; c++) begin
                per[c*WIDTH +: WIDTH] = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom)
                                                                    : WIDTH'($urandom_range(0, 4));
                en[c]  = ($urandom_range(0, 9) < 7);
                am[c]  = ($urandom_range(0, 9) == 0);
                clr[c] = ($urandom_range(0, 19) == 0);
            end
            if (i % 64 == 0) md = NUM_CH'($urandom);
            applyStimulus(($urandom_range(0, 199) == 0), en, per, md, am, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
